// File: rtl/demux4x16_wb_pkg.sv
// Shared definitions for the 4-way write-side demux: select codes, stage states
// and the one-hot commit strobe helper.
package demux4x16_wb_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } sel_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_e;

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux4x16_wb_if.sv
// Producer-side handshake, downstream stall and destination outputs of the demux.
interface demux4x16_wb_if #(parameter int W = 16);

    logic [W-1:0] I;
    logic [1:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic         hold;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] D;
    logic [3:0]   we;
    logic         busy;

    modport slave  (input  I, s, in_valid, hold,
                    output in_ready, A, B, C, D, we, busy);
    modport master (output I, s, in_valid, hold,
                    input  in_ready, A, B, C, D, we, busy);

endinterface

// File: rtl/demux4x16_wb_stage_reg.sv
// Single-entry ready/valid holding register; frees its slot on the same edge
// that the entry commits, so back-to-back writes flow at one per cycle.
module demux4x16_wb_stage_reg
    import demux4x16_wb_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         hold,
    output logic         in_ready,
    output logic         stage_valid,
    output logic [W-1:0] stage_data,
    output logic [1:0]   stage_sel
);

    stage_state_e state_q, state_d;
    logic         accept;

    assign stage_valid = (state_q == FULL);
    assign in_ready    = !stage_valid || !hold;
    assign accept      = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept)          state_d = FULL;
            FULL:  if (!hold && !accept) state_d = EMPTY;
            default:                    state_d = EMPTY;
        endcase
    end

    // NOTE: payload is left unreset on purpose; stage_valid gates every use of it.
    always_ff @(posedge CLK) begin
        if (accept) begin
            stage_data <= in_data;
            stage_sel  <= in_sel;
        end
    end

endmodule

// File: rtl/demux4x16_wb.sv
// Write-side 4-way demux: stages one tagged value, then commits it into the
// selected destination register with a one-cycle one-hot write strobe.
module demux4x16_wb
    import demux4x16_wb_pkg::*;
#(
    parameter int           W         = W_DEFAULT,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input logic            CLK,
    input logic            Reset,
    demux4x16_wb_if.slave  bus
);

    logic         stage_valid;
    logic [W-1:0] stage_data;
    logic [1:0]   stage_sel;
    logic         commit;
    logic [W-1:0] dest [4];
    logic [3:0]   we_q;

    demux4x16_wb_stage_reg #(.W(W)) u_stage (
        .CLK         (CLK),
        .Reset       (Reset),
        .in_valid    (bus.in_valid),
        .in_data     (bus.I),
        .in_sel      (bus.s),
        .hold        (bus.hold),
        .in_ready    (bus.in_ready),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .stage_sel   (stage_sel)
    );

    assign commit = stage_valid && !bus.hold;

    // Architectural holding registers must power up to a known value, so all four are reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 4; k++) dest[k] <= RESET_VAL;
            we_q <= '0;
        end else begin
            we_q <= '0;
            if (commit) begin
                dest[stage_sel] <= stage_data;
                we_q            <= onehot4(stage_sel);
            end
        end
    end

    assign bus.A    = dest[SEL_A];
    assign bus.B    = dest[SEL_B];
    assign bus.C    = dest[SEL_C];
    assign bus.D    = dest[SEL_D];
    assign bus.we   = we_q;
    assign bus.busy = stage_valid;

endmodule

// File: tb/tb_demux4x16_wb.sv
// Directed bench for demux4x16_wb: inputs change and outputs are sampled on the
// falling edge, so each tick() spans exactly one rising edge.
module tb_demux4x16_wb;

    logic CLK = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;

    demux4x16_wb_if #(.W(16)) bus ();

    demux4x16_wb #(.W(16), .RESET_VAL(16'h0000)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] sel);
        bus.in_valid = v;
        bus.I        = d;
        bus.s        = sel;
    endtask

    initial begin
        Reset = 1'b1;
        bus.hold = 1'b0;
        drive(1'b0, 16'h0, 2'd0);
        tick();
        check("rst_A", bus.A, 16'h0);
        check("rst_D", bus.D, 16'h0);
        check("rst_we", bus.we, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        Reset = 1'b0;
        check("rst_ready", bus.in_ready, 1'b1);

        // Sequential writes to A, B, C, D, one per cycle
        drive(1'b1, 16'd1, 2'd0);
        tick();
        check("seq0_busy", bus.busy, 1'b1);
        check("seq0_we", bus.we, 4'b0000);
        check("seq0_A", bus.A, 16'h0);
        drive(1'b1, 16'd2, 2'd1);
        tick();
        check("seq1_A", bus.A, 16'd1);
        check("seq1_we", bus.we, 4'b0001);
        check("seq1_B", bus.B, 16'h0);
        drive(1'b1, 16'd3, 2'd2);
        tick();
        check("seq2_B", bus.B, 16'd2);
        check("seq2_we", bus.we, 4'b0010);
        check("seq2_A", bus.A, 16'd1);
        drive(1'b1, 16'd4, 2'd3);
        tick();
        check("seq3_C", bus.C, 16'd3);
        check("seq3_we", bus.we, 4'b0100);
        drive(1'b0, 16'd0, 2'd0);
        tick();
        check("seq4_D", bus.D, 16'd4);
        check("seq4_we", bus.we, 4'b1000);
        check("seq4_busy", bus.busy, 1'b0);
        tick();
        check("seq5_we", bus.we, 4'b0000);

        // Stall: accept while EMPTY with hold high, then a blocked second write
        bus.hold = 1'b1;
        drive(1'b1, 16'hBEEF, 2'd2);
        tick();
        check("stall_busy", bus.busy, 1'b1);
        check("stall_ready", bus.in_ready, 1'b0);
        drive(1'b1, 16'h5555, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_C", i), bus.C, 16'd3);
            check($sformatf("stall%0d_we", i), bus.we, 4'b0000);
            check($sformatf("stall%0d_ready", i), bus.in_ready, 1'b0);
            check($sformatf("stall%0d_A", i), bus.A, 16'd1);
        end
        bus.hold = 1'b0;
        tick();
        check("unstall_C", bus.C, 16'hBEEF);
        check("unstall_we", bus.we, 4'b0100);
        check("unstall_A", bus.A, 16'd1);
        check("unstall_busy", bus.busy, 1'b1);
        drive(1'b0, 16'd0, 2'd0);
        tick();
        check("blocked_A", bus.A, 16'h5555);
        check("blocked_we", bus.we, 4'b0001);
        check("blocked_busy", bus.busy, 1'b0);

        // Same-destination overwrite
        drive(1'b1, 16'd7, 2'd1);
        tick();
        drive(1'b1, 16'd9, 2'd1);
        tick();
        check("ow0_B", bus.B, 16'd7);
        check("ow0_we", bus.we, 4'b0010);
        drive(1'b0, 16'd0, 2'd0);
        tick();
        check("ow1_B", bus.B, 16'd9);
        check("ow1_we", bus.we, 4'b0010);
        tick();
        check("ow2_we", bus.we, 4'b0000);

        // Width boundary on D
        drive(1'b1, 16'hFFFF, 2'd3);
        tick();
        drive(1'b1, 16'h0000, 2'd3);
        tick();
        check("wd0_D", bus.D, 16'hFFFF);
        check("wd0_we", bus.we, 4'b1000);
        drive(1'b0, 16'd0, 2'd0);
        tick();
        check("wd1_D", bus.D, 16'h0000);
        check("wd1_A", bus.A, 16'h5555);
        check("wd1_B", bus.B, 16'd9);
        check("wd1_C", bus.C, 16'hBEEF);

        // Async reset mid-stream with a held FULL stage
        drive(1'b1, 16'h1234, 2'd0);
        tick();
        drive(1'b0, 16'd0, 2'd0);
        tick();
        check("pre_rst_A", bus.A, 16'h1234);
        bus.hold = 1'b1;
        drive(1'b1, 16'hAAAA, 2'd1);
        tick();
        check("pre_rst_busy", bus.busy, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("arst_A", bus.A, 16'h0);
        check("arst_B", bus.B, 16'h0);
        check("arst_C", bus.C, 16'h0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_we", bus.we, 4'b0000);
        tick();
        Reset = 1'b0;
        bus.hold = 1'b0;
        drive(1'b0, 16'd0, 2'd0);
        check("post_rst_ready", bus.in_ready, 1'b1);
        tick();
        check("post_rst_B", bus.B, 16'h0);
        check("post_rst_we", bus.we, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux4x16_wb.md
Name: demux4x16_wb

Overview:
- Write-side counterpart of the 4-way 16-bit result mux: routes one 16-bit value, tagged with a 2-bit select `s`, into one of four held 16-bit destinations A/B/C/D.
- Sits between the ALU result path and the four architectural holding registers.
- Two stages: an input stage register, then a commit into the selected destination.
- Ready/valid input handshake, plus a downstream `hold` stall.

Parameters:
- W, 16, data width of `I` and of each destination A/B/C/D.
- RESET_VAL, 0, value loaded into A/B/C/D on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- I  input  W  data to be written.
- s  input  2  destination select: 0→A, 1→B, 2→C, 3→D.
- in_valid  input  1  I/s are valid this cycle.
- in_ready  output  1  stage can accept this cycle.
- hold  input  1  downstream stall; blocks commit while high.
- A  output  W  destination 0 contents.
- B  output  W  destination 1 contents.
- C  output  W  destination 2 contents.
- D  output  W  destination 3 contents.
- we  output  4  one-hot commit strobe; bit k high for the one cycle after destination k is updated.
- busy  output  1  stage holds an uncommitted entry.

Behaviour:
- Reset (async, any time):
  - stage_valid=0.
  - A=B=C=D=RESET_VAL.
  - we=0, busy=0.
  - An in-flight or held entry is discarded.
  - After deassertion, in_ready=1 immediately.
- State: stage_valid, stage_data[W], stage_sel[2]. Two-state FSM, EMPTY (stage_valid=0) and FULL (stage_valid=1).
- Combinational outputs:
  - in_ready = !stage_valid || !hold.
  - busy = stage_valid.
- Commit (edge where stage_valid && !hold):
  - Destination[stage_sel] <= stage_data.
  - we <= one-hot(stage_sel).
  - All other destinations are unchanged.
- If no commit occurs on an edge, we <= 0.
- Accept (edge where in_valid && in_ready):
  - stage_data <= I, stage_sel <= s, stage_valid <= 1.
- Transitions:
  - EMPTY + accept → FULL.
  - FULL + commit + accept → FULL; back-to-back throughput of 1 write/cycle.
  - FULL + commit, no accept → EMPTY.
  - FULL + hold → FULL, stage frozen, in_ready=0.
- Latency: a write accepted at edge N appears on its destination, with its we bit high, after edge N+1, provided hold is low at N+1.
- in_valid while in_ready=0: not accepted. The producer must keep I/s stable until accepted; the block ignores the inputs meanwhile.
- Same destination on consecutive writes: last write wins, in order; we bit high for consecutive cycles.
- hold while EMPTY: has no effect; accept still proceeds.
- hold rising while FULL: no commit; we=0 from the next edge.
- Width: I is stored unmodified; no truncation or extension; s uses all 4 codes.

Decomposition:
- Shared package:
  - select encodings SEL_A=0, SEL_B=1, SEL_C=2, SEL_D=3.
  - default W=16.
  - function onehot4(sel) → 4-bit.
- Sub-module stage_reg: the single-entry ready/valid holding register (valid/data/sel, in_ready logic).
- Top level: commit decode and the four destination registers.

Test Plan:
- Reset check: assert Reset mid-stream with a FULL stage and A=0x1234 → A..D=0, we=0, busy=0 immediately (async); in_ready=1 after release.
- Sequential writes, one per cycle, hold=0: (I=1,s=0), (I=2,s=1), (I=3,s=2), (I=4,s=3) → one cycle after each accept, A=1, B=2, C=3, D=4 in order; we=0001, 0010, 0100, 1000 on consecutive cycles; unselected destinations unchanged.
- Stall: accept (I=0xBEEF, s=2) with hold=1 for 3 cycles → C unchanged, in_ready=0, busy=1, we=0; drop hold → C=0xBEEF and we=0100 the next edge.
- Blocked input: during the stall, drive in_valid=1 with (I=0x5555, s=0) → not accepted; after release it is accepted one cycle later; A=0x5555 only after the C commit.
- Same-destination overwrite: (I=7,s=1) then (I=9,s=1) back-to-back → B=7 then B=9; we[1] high 2 cycles.
- Width/boundary: I=0xFFFF to s=3, then I=0x0000 to s=3 → D=0xFFFF then 0x0000; A/B/C retain prior values.
